sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single-channel SDRAM controller (edge-triggered rd/wr, level busy, 25-bit byte address, 16-bit data) between three requesters: p0 = CPU, p1 = video/DMA, p2 = save/loader.
- Latches one pending request per port and sequences the controller's rd/wr edge handshake.
- Inserts periodic refresh cycles. The controller only refreshes when a cycle re-reads the currently open address, so the arbiter must generate these itself.
- Sits between the core bus logic and the controller, in the same clk domain.

Parameters:
- REFRESH_CYCLES, 780, clk cycles between forced refresh cycles (7.8 us at 100 MHz); counter width is clog2(REFRESH_CYCLES+1).
- ROUND_ROBIN, 0, 0 = fixed priority p0>p1>p2; 1 = rotating priority among ports.

Ports:
- clk  in  1  system clock, same as controller clk.
- reset  in  1  synchronous, active-high.
- pN_req  in  1  (N=0..2) one-cycle request strobe; sampled only when pN_busy=0.
- pN_we  in  1  1 = write, 0 = read; sampled with pN_req.
- pN_word  in  1  1 = 16-bit access, 0 = byte access; sampled with pN_req.
- pN_addr  in  25  byte address; sampled with pN_req.
- pN_din  in  16  write data; sampled with pN_req.
- pN_dout  out  16  read data; valid from the pN_ack cycle and held until the next pN read ack.
- pN_ack  out  1  one-cycle completion pulse, for reads and writes.
- pN_busy  out  1  request pending or in flight.
- ctl_rd, ctl_wr  out  1  level requests to the controller.
- ctl_word  out  1  to controller word.
- ctl_addr  out  25  to controller addr.
- ctl_din  out  16  to controller din.
- ctl_dout  in  16  from controller dout.
- ctl_busy  in  1  from controller busy.

Behaviour:
- Reset values: all pN_ack = 0, all pN_busy = 0, pending flags cleared, pN_dout = 0, ctl_rd = ctl_wr = 0, ctl_word = 1, ctl_addr = 25'h1FFFFFF, ctl_din = 0. Refresh counter = 0; refresh address register raddr = 25'h1FFFFFF. FSM enters RESYNC.
- Request capture: pN_req while pN_busy=0 latches we/word/addr/din into a per-port slot and sets pending, so pN_busy=1 on the next cycle. pN_req while pN_busy=1 is ignored.
- Refresh counter: increments every cycle, saturating at REFRESH_CYCLES. refresh_due = (count == REFRESH_CYCLES). The counter clears to 0 when a refresh cycle is granted.
- FSM states:
  - RESYNC: ctl_rd = ctl_wr = 0. Move to IDLE when ctl_busy = 0.
  - IDLE: choose a grant in this order: refresh_due first, then ports.
    - Fixed priority: p0 > p1 > p2.
    - ROUND_ROBIN: start searching at the port after the last granted port.
    - On grant, drive ctl_addr/ctl_word/ctl_din from the slot and set ctl_rd = ~we, ctl_wr = we (registered, visible the next cycle). Go to ISSUE.
    - A refresh grant drives ctl_rd = 1, ctl_addr = raddr, ctl_word = 1.
    - With nothing pending, stay in IDLE.
  - ISSUE: hold ctl_* stable. When ctl_busy = 1, go to WAIT. A controller still in init simply delays this state; there is no timeout.
  - WAIT: hold ctl_* stable. When ctl_busy = 0, go to DONE.
  - DONE: drop ctl_rd/ctl_wr for this cycle. This guarantees at least one low cycle, so the controller sees a fresh edge on the next grant.
    - For a port grant: pulse pN_ack, clear pending.
    - For a port read: copy ctl_dout into pN_dout.
    - Refresh grants produce no ack.
    - Go to IDLE.
- raddr tracking: after a port read completes, raddr = that address. After a port write completes, raddr = 25'h1FFFFFF, because the controller's open address becomes all-ones after a write. A refresh read therefore matches the open address and becomes an auto-refresh.
- Latency: an idle system with a single pN_req produces ctl_rd/ctl_wr high 2 cycles after the strobe. pN_ack follows 1 cycle after ctl_busy falls.
- Simultaneous events:
  - A req on the same cycle as that port's ack is not accepted, because busy is still 1. The requester retries after ack.
  - Several ports becoming pending in the same cycle are granted in priority order, one transaction each.
  - refresh_due together with pending ports: refresh goes first; ports are delayed by one transaction.
- Reset mid-operation: all pending requests are dropped with no ack. The FSM goes to RESYNC and waits out any controller cycle still in flight.

Test Plan:
- Single read: controller model returns 16'hBEEF; p1 reads 25'h0000100 -> ctl_rd=1 with ctl_addr=25'h0000100, p1_ack is a 1-cycle pulse, p1_dout=16'hBEEF, p1_busy falls with the ack.
- Contention: p0, p1, p2 strobe in the same cycle, ROUND_ROBIN=0 -> grants in order p0, p1, p2, acks on three separate transactions, ctl_rd/wr low for ≥1 cycle between them. ROUND_ROBIN=1 with last grant p0 and p0+p2 pending -> p2 granted first.
- Refresh: REFRESH_CYCLES=16 with no port traffic -> ctl_rd pulses with ctl_addr=25'h1FFFFFF every ~16+transaction cycles, and no acks. After p0 reads 25'h0000200, the next refresh uses 25'h0000200. After a p0 write, the next refresh returns to all-ones.
- Write: p2 writes byte 8'h5A at 25'h0000003 with word=0 -> ctl_wr=1, ctl_word=0, ctl_din=16'h??5A from the slot, p2_ack pulses, p2_dout unchanged.
- Held-off controller: ctl_busy held 0 for 50 cycles after ctl_rd rises (init) -> arbiter stays in ISSUE with ctl_rd=1, then completes normally once busy toggles.
- Reset during WAIT with ctl_busy=1 -> no ack, all pN_busy=0, ctl_rd/ctl_wr=0. Next grant is issued only after ctl_busy returns to 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of the single-channel SDRAM controller.
// Latches one request per port, sequences the rd/wr edge handshake and inserts refresh reads.
module sdram_port_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 780,
  parameter bit          ROUND_ROBIN    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_word,
  input  logic [24:0] p0_addr,
  input  logic [15:0] p0_din,
  output logic [15:0] p0_dout,
  output logic        p0_ack,
  output logic        p0_busy,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_word,
  input  logic [24:0] p1_addr,
  input  logic [15:0] p1_din,
  output logic [15:0] p1_dout,
  output logic        p1_ack,
  output logic        p1_busy,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic        p2_word,
  input  logic [24:0] p2_addr,
  input  logic [15:0] p2_din,
  output logic [15:0] p2_dout,
  output logic        p2_ack,
  output logic        p2_busy,
  output logic        ctl_rd,
  output logic        ctl_wr,
  output logic        ctl_word,
  output logic [24:0] ctl_addr,
  output logic [15:0] ctl_din,
  input  logic [15:0] ctl_dout,
  input  logic        ctl_busy
);

  localparam int unsigned CntW     = $clog2(REFRESH_CYCLES + 1);
  localparam logic [24:0] AddrOnes = 25'h1FFFFFF;

  typedef enum logic [2:0] {StResync, StIdle, StIssue, StWait, StDone} state_e;

  logic [2:0]  req_in, we_in, word_in;
  logic [24:0] addr_in [3];
  logic [15:0] din_in  [3];

  assign req_in     = {p2_req, p1_req, p0_req};
  assign we_in      = {p2_we, p1_we, p0_we};
  assign word_in    = {p2_word, p1_word, p0_word};
  assign addr_in[0] = p0_addr;
  assign addr_in[1] = p1_addr;
  assign addr_in[2] = p2_addr;
  assign din_in[0]  = p0_din;
  assign din_in[1]  = p1_din;
  assign din_in[2]  = p2_din;

  state_e      state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  slot_we_q, slot_we_d, slot_word_q, slot_word_d;
  logic [24:0] slot_addr_q [3];
  logic [24:0] slot_addr_d [3];
  logic [15:0] slot_din_q [3];
  logic [15:0] slot_din_d [3];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [24:0] raddr_q, raddr_d;
  logic [1:0]  gnt_q, gnt_d, last_q, last_d;
  logic        gnt_ref_q, gnt_ref_d;
  logic        ctl_rd_q, ctl_rd_d, ctl_wr_q, ctl_wr_d, ctl_word_q, ctl_word_d;
  logic [24:0] ctl_addr_q, ctl_addr_d;
  logic [15:0] ctl_din_q, ctl_din_d;
  logic [2:0]  ack_q, ack_d;
  logic [15:0] dout_q [3];
  logic [15:0] dout_d [3];

  logic        refresh_due;
  logic        sel_valid;
  logic [1:0]  sel_port;

  assign refresh_due = (cnt_q == CntW'(REFRESH_CYCLES));

  // Search order starts at port 0, or after the last granted port when rotating.
  always_comb begin
    logic [1:0] start;
    logic [2:0] cand;
    sel_valid = 1'b0;
    sel_port  = 2'd0;
    start     = 2'd0;
    cand      = 3'd0;
    if (ROUND_ROBIN) start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, start} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (pend_q[cand[1:0]]) begin
        sel_valid = 1'b1;
        sel_port  = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    slot_we_d   = slot_we_q;
    slot_word_d = slot_word_q;
    slot_addr_d = slot_addr_q;
    slot_din_d  = slot_din_q;
    cnt_d       = refresh_due ? cnt_q : cnt_q + CntW'(1);
    raddr_d     = raddr_q;
    gnt_d       = gnt_q;
    gnt_ref_d   = gnt_ref_q;
    last_d      = last_q;
    ctl_rd_d    = ctl_rd_q;
    ctl_wr_d    = ctl_wr_q;
    ctl_word_d  = ctl_word_q;
    ctl_addr_d  = ctl_addr_q;
    ctl_din_d   = ctl_din_q;
    ack_d       = 3'b000;
    dout_d      = dout_q;

    for (int i = 0; i < 3; i++) begin
      if (req_in[i] && !pend_q[i]) begin
        pend_d[i]      = 1'b1;
        slot_we_d[i]   = we_in[i];
        slot_word_d[i] = word_in[i];
        slot_addr_d[i] = addr_in[i];
        slot_din_d[i]  = din_in[i];
      end
    end

    unique case (state_q)
      StResync: begin
        ctl_rd_d = 1'b0;
        ctl_wr_d = 1'b0;
        if (!ctl_busy) state_d = StIdle;
      end
      StIdle: begin
        if (refresh_due) begin
          // Re-reading the open address makes the controller auto-refresh.
          gnt_ref_d  = 1'b1;
          cnt_d      = '0;
          ctl_rd_d   = 1'b1;
          ctl_wr_d   = 1'b0;
          ctl_addr_d = raddr_q;
          ctl_word_d = 1'b1;
          state_d    = StIssue;
        end else if (sel_valid) begin
          gnt_ref_d  = 1'b0;
          gnt_d      = sel_port;
          last_d     = sel_port;
          ctl_rd_d   = ~slot_we_q[sel_port];
          ctl_wr_d   = slot_we_q[sel_port];
          ctl_addr_d = slot_addr_q[sel_port];
          ctl_word_d = slot_word_q[sel_port];
          ctl_din_d  = slot_din_q[sel_port];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (ctl_busy) state_d = StWait;
      end
      StWait: begin
        if (!ctl_busy) begin
          state_d  = StDone;
          ctl_rd_d = 1'b0;
          ctl_wr_d = 1'b0;
          if (!gnt_ref_q) begin
            ack_d[gnt_q] = 1'b1;
            if (!slot_we_q[gnt_q]) begin
              dout_d[gnt_q] = ctl_dout;
              raddr_d       = slot_addr_q[gnt_q];
            end else begin
              raddr_d = AddrOnes;
            end
          end
        end
      end
      StDone: begin
        // Pending drops only now so a strobe during the ack cycle is still refused.
        if (!gnt_ref_q) pend_d[gnt_q] = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StResync;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StResync;
      pend_q     <= 3'b000;
      cnt_q      <= '0;
      raddr_q    <= AddrOnes;
      gnt_q      <= 2'd0;
      gnt_ref_q  <= 1'b0;
      last_q     <= 2'd2;
      ctl_rd_q   <= 1'b0;
      ctl_wr_q   <= 1'b0;
      ctl_word_q <= 1'b1;
      ctl_addr_q <= AddrOnes;
      ctl_din_q  <= 16'h0000;
      ack_q      <= 3'b000;
      dout_q     <= '{default: 16'h0000};
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      gnt_q      <= gnt_d;
      gnt_ref_q  <= gnt_ref_d;
      last_q     <= last_d;
      ctl_rd_q   <= ctl_rd_d;
      ctl_wr_q   <= ctl_wr_d;
      ctl_word_q <= ctl_word_d;
      ctl_addr_q <= ctl_addr_d;
      ctl_din_q  <= ctl_din_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_we_q   <= slot_we_d;
    slot_word_q <= slot_word_d;
    slot_addr_q <= slot_addr_d;
    slot_din_q  <= slot_din_d;
  end

  assign ctl_rd   = ctl_rd_q;
  assign ctl_wr   = ctl_wr_q;
  assign ctl_word = ctl_word_q;
  assign ctl_addr = ctl_addr_q;
  assign ctl_din  = ctl_din_q;
  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p2_ack   = ack_q[2];
  assign p0_busy  = pend_q[0];
  assign p1_busy  = pend_q[1];
  assign p2_busy  = pend_q[2];
  assign p0_dout  = dout_q[0];
  assign p1_dout  = dout_q[1];
  assign p2_dout  = dout_q[2];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench: instance 0 fixed priority, instance 1 rotating, each against a
// transaction-level model of request capture, grant order, refresh timing and completion.
module tb_sdram_port_arbiter;

  localparam int unsigned RefCycles = 16;
  localparam int          NumCyc    = 6000;
  localparam logic [24:0] Ones      = 25'h1FFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [2:0]  req      [2];
  logic [2:0]  we       [2];
  logic [2:0]  word     [2];
  logic [24:0] addr     [2][3];
  logic [15:0] din      [2][3];
  logic [15:0] dout     [2][3];
  logic [2:0]  ack      [2];
  logic [2:0]  busy     [2];
  logic        ctl_rd   [2];
  logic        ctl_wr   [2];
  logic        ctl_word [2];
  logic        ctl_busy [2];
  logic [24:0] ctl_addr [2];
  logic [15:0] ctl_din  [2];
  logic [15:0] ctl_dout [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_port_arbiter #(
      .REFRESH_CYCLES(RefCycles),
      .ROUND_ROBIN   (1'(g))
    ) u_dut (
      .clk     (clk),
      .reset   (rst[g]),
      .p0_req  (req[g][0]),
      .p0_we   (we[g][0]),
      .p0_word (word[g][0]),
      .p0_addr (addr[g][0]),
      .p0_din  (din[g][0]),
      .p0_dout (dout[g][0]),
      .p0_ack  (ack[g][0]),
      .p0_busy (busy[g][0]),
      .p1_req  (req[g][1]),
      .p1_we   (we[g][1]),
      .p1_word (word[g][1]),
      .p1_addr (addr[g][1]),
      .p1_din  (din[g][1]),
      .p1_dout (dout[g][1]),
      .p1_ack  (ack[g][1]),
      .p1_busy (busy[g][1]),
      .p2_req  (req[g][2]),
      .p2_we   (we[g][2]),
      .p2_word (word[g][2]),
      .p2_addr (addr[g][2]),
      .p2_din  (din[g][2]),
      .p2_dout (dout[g][2]),
      .p2_ack  (ack[g][2]),
      .p2_busy (busy[g][2]),
      .ctl_rd  (ctl_rd[g]),
      .ctl_wr  (ctl_wr[g]),
      .ctl_word(ctl_word[g]),
      .ctl_addr(ctl_addr[g]),
      .ctl_din (ctl_din[g]),
      .ctl_dout(ctl_dout[g]),
      .ctl_busy(ctl_busy[g])
    );
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Model state, one set per instance.
  logic [2:0]  m_pend  [2];
  logic [2:0]  m_clr   [2];
  logic        m_we    [2][3];
  logic        m_word  [2][3];
  logic [24:0] m_addr  [2][3];
  logic [15:0] m_din   [2][3];
  logic [15:0] m_dout  [2][3];
  logic [24:0] m_raddr [2];
  int          m_g     [2];  // edge at which the refresh interval last restarted
  int          m_idle  [2];  // first edge at which a grant may be decided
  bit          m_resync[2];
  int          m_last  [2];
  bit          t_act   [2];
  bit          t_ref   [2];
  bit          t_we    [2];
  bit          t_word  [2];
  int          t_port  [2];
  logic [24:0] t_addr  [2];
  logic [15:0] t_din   [2];
  bit          a_valid [2];
  int          a_iter  [2];
  int          c_st    [2];
  int          c_dly   [2];
  int          c_cnt   [2];
  int          rst_hold[2];

  task automatic step(input int i, input int k);
    logic [2:0] pend_old;
    logic [2:0] ackm;
    bit         due;
    bit         exp_rise;
    bit         found;
    int         p;
    int         c;
    string      pre;
    pre      = $sformatf("i%0d k%0d", i, k);
    pend_old = m_pend[i];
    due      = (k - 1 - m_g[i]) >= int'(RefCycles);
    exp_rise = 1'b0;
    ackm     = 3'b000;
    if (rst[i]) begin
      m_pend[i]   = 3'b000;
      m_clr[i]    = 3'b000;
      m_g[i]      = k;
      m_raddr[i]  = Ones;
      m_last[i]   = 2;
      t_act[i]    = 1'b0;
      a_valid[i]  = 1'b0;
      m_resync[i] = 1'b1;
      for (int j = 0; j < 3; j++) m_dout[i][j] = 16'h0000;
    end else begin
      exp_rise = !t_act[i] && !m_resync[i] && (k >= m_idle[i]) && ((pend_old != 3'b000) || due);
      if (m_resync[i] && !ctl_busy[i]) begin
        m_resync[i] = 1'b0;
        m_idle[i]   = k + 1;
      end
      m_pend[i] = pend_old & ~m_clr[i];
      m_clr[i]  = 3'b000;
      for (int j = 0; j < 3; j++) begin
        if (req[i][j] && !pend_old[j]) begin
          m_pend[i][j] = 1'b1;
          m_we[i][j]   = we[i][j];
          m_word[i][j] = word[i][j];
          m_addr[i][j] = addr[i][j];
          m_din[i][j]  = din[i][j];
        end
      end
      if (exp_rise) begin
        t_act[i] = 1'b1;
        if (due) begin
          t_ref[i]  = 1'b1;
          t_we[i]   = 1'b0;
          t_word[i] = 1'b1;
          t_addr[i] = m_raddr[i];
          m_g[i]    = k;
        end else begin
          found = 1'b0;
          p     = 0;
          for (int s = 0; s < 3; s++) begin
            c = (i == 1) ? (m_last[i] + 1 + s) % 3 : s;
            if (!found && pend_old[c]) begin
              found = 1'b1;
              p     = c;
            end
          end
          t_ref[i]  = 1'b0;
          t_port[i] = p;
          t_we[i]   = m_we[i][p];
          t_word[i] = m_word[i][p];
          t_addr[i] = m_addr[i][p];
          t_din[i]  = m_din[i][p];
          m_last[i] = p;
        end
      end
      if (a_valid[i] && k == a_iter[i]) begin
        a_valid[i]        = 1'b0;
        ackm              = 3'b001 << t_port[i];
        m_clr[i][t_port[i]] = 1'b1;
        if (!t_we[i]) begin
          m_dout[i][t_port[i]] = ctl_dout[i];
          m_raddr[i]           = t_addr[i];
        end else begin
          m_raddr[i] = Ones;
        end
      end
    end

    check_eq({pre, " ack"}, 32'(ack[i]), 32'(ackm));
    check_eq({pre, " busy"}, 32'(busy[i]), 32'(m_pend[i]));
    for (int j = 0; j < 3; j++)
      check_eq($sformatf("%s dout%0d", pre, j), 32'(dout[i][j]), 32'(m_dout[i][j]));
    check_eq({pre, " ctl_rd"}, 32'(ctl_rd[i]), 32'(t_act[i] && !t_we[i]));
    check_eq({pre, " ctl_wr"}, 32'(ctl_wr[i]), 32'(t_act[i] && t_we[i]));
    if (t_act[i]) begin
      check_eq({pre, " ctl_addr"}, 32'(ctl_addr[i]), 32'(t_addr[i]));
      check_eq({pre, " ctl_word"}, 32'(ctl_word[i]), 32'(t_word[i]));
      if (t_we[i]) check_eq({pre, " ctl_din"}, 32'(ctl_din[i]), 32'(t_din[i]));
    end
    if (rst[i]) begin
      check_eq({pre, " rst_addr"}, 32'(ctl_addr[i]), 32'(Ones));
      check_eq({pre, " rst_word"}, 32'(ctl_word[i]), 32'd1);
      check_eq({pre, " rst_din"}, 32'(ctl_din[i]), 32'd0);
    end

    // Controller model: optional start delay (sometimes a long init hold-off), then busy.
    if (exp_rise) begin
      c_st[i]  = 1;
      c_dly[i] = ($urandom_range(0, 19) == 0) ? 50 : int'($urandom_range(0, 3));
    end
    if (c_st[i] == 1) begin
      if (c_dly[i] == 0) begin
        ctl_busy[i] = 1'b1;
        c_st[i]     = 2;
        c_cnt[i]    = int'($urandom_range(1, 4));
      end else begin
        c_dly[i]--;
      end
    end else if (c_st[i] == 2) begin
      c_cnt[i]--;
      if (c_cnt[i] == 0) begin
        ctl_busy[i] = 1'b0;
        ctl_dout[i] = 16'($urandom);
        c_st[i]     = 0;
        if (t_act[i]) begin
          t_act[i]  = 1'b0;
          m_idle[i] = k + 3;
          if (!t_ref[i]) begin
            a_valid[i] = 1'b1;
            a_iter[i]  = k + 1;
          end
        end
      end
    end

    // Occasional reset while the controller is busy; the aborted cycle keeps running.
    if (rst_hold[i] > 0) begin
      rst[i] = 1'b1;
      rst_hold[i]--;
    end else if (c_st[i] == 2 && k > 200 && k < NumCyc - 300 && $urandom_range(0, 59) == 0) begin
      rst[i]      = 1'b1;
      rst_hold[i] = 1;
      c_cnt[i]    = c_cnt[i] + 5;
    end else begin
      rst[i] = 1'b0;
    end
  endtask

  task automatic drive(input int i, input int k);
    int unsigned rate;
    rate = (k < 1500) ? 30 : (k < 2300) ? 0 : 10;
    for (int j = 0; j < 3; j++) begin
      req[i][j]  = ($urandom_range(0, 99) < rate);
      we[i][j]   = 1'($urandom_range(0, 1));
      word[i][j] = 1'($urandom_range(0, 1));
      addr[i][j] = ($urandom_range(0, 1) == 1) ? 25'($urandom) : 25'($urandom_range(0, 1023));
      din[i][j]  = 16'($urandom);
    end
    if (k >= 2300 && $urandom_range(0, 29) == 0) req[i] = 3'b111;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]      = 1'b1;
      rst_hold[i] = 2;
      req[i]      = 3'b000;
      we[i]       = 3'b000;
      word[i]     = 3'b000;
      ctl_busy[i] = 1'b0;
      ctl_dout[i] = 16'h0000;
      m_pend[i]   = 3'b000;
      m_clr[i]    = 3'b000;
      m_raddr[i]  = Ones;
      m_g[i]      = 0;
      m_idle[i]   = 0;
      m_resync[i] = 1'b1;
      m_last[i]   = 2;
      t_act[i]    = 1'b0;
      t_ref[i]    = 1'b0;
      t_we[i]     = 1'b0;
      t_word[i]   = 1'b1;
      t_port[i]   = 0;
      t_addr[i]   = Ones;
      t_din[i]    = 16'h0000;
      a_valid[i]  = 1'b0;
      a_iter[i]   = 0;
      c_st[i]     = 0;
      c_dly[i]    = 0;
      c_cnt[i]    = 0;
      for (int j = 0; j < 3; j++) begin
        addr[i][j]   = 25'h0;
        din[i][j]    = 16'h0;
        m_we[i][j]   = 1'b0;
        m_word[i][j] = 1'b0;
        m_addr[i][j] = 25'h0;
        m_din[i][j]  = 16'h0;
        m_dout[i][j] = 16'h0;
      end
    end
    for (int k = 1; k <= NumCyc; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        step(i, k);
        drive(i, k);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
